prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Writer side of the instruction-memory interface: receives a program as a byte stream
//  (valid/ready), packs it into 32-bit little-endian words and writes them to the
//  instruction RAM at byte addresses 0,4,8,...
//  Holds the CPU (cpu_hold keeps PC at 0) until the whole image is written, then releases it.
//  Sits between the host byte source and the instruction RAM write port, beside the core.
// PARAMETERS
//  ADDR_W     8   instruction-memory byte-address width (matches PC width)
//  MAX_WORDS  64  largest accepted program, in words (must be <= 2**ADDR_W/4)
// PORTS
//  clk        in   1       single clock; all logic on posedge
//  rst_n      in   1       synchronous reset, active-low
//  start      in   1       1-cycle pulse; begin a load (honoured only in IDLE/DONE/ERR)
//  s_data     in   8       stream byte
//  s_valid    in   1       s_data valid
//  s_ready    out  1       loader accepts a byte this cycle
//  mem_addr   out  ADDR_W  write byte address (word aligned)
//  mem_wdata  out  32      write data
//  mem_we     out  1       write strobe, 1 cycle per word
//  cpu_hold   out  1       1 = core held at PC=0, no fetch
//  done       out  1       level; image written (and verified), core released
//  err        out  1       level; bad length or checksum; core stays held
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state IDLE, cpu_hold=1, s_ready=0, mem_we=0, done=0, err=0,
//    mem_addr=0, mem_wdata=0, counters cleared. Reset mid-load aborts; words already written
//    stay in RAM.
//  - Byte accepted iff s_valid & s_ready at posedge; s_ready=1 only in LEN0/LEN1/DATA/CHK.
//  - Frame: LEN lo, LEN hi (16-bit word count N), then 4*N payload bytes, LSB first per word.
//  - FSM: IDLE -start-> LEN0 -byte-> LEN1 -byte-> DATA, or ERR if N==0 or N>MAX_WORDS.
//    DATA: after the 4th byte of a word, mem_we=1 in the NEXT cycle with mem_addr=4*idx and
//    the assembled mem_wdata; idx increments.
//    After word N-1 is accepted: -> CHK (macro on) or DONE (macro off).
//  - done rises the cycle after the final mem_we, so RAM is written before cpu_hold falls.
//    In DONE: cpu_hold=0, done=1.
//  - start in DONE/ERR: clear done/err, set cpu_hold=1, go to LEN0, word index back to 0.
//    start in LEN0/LEN1/DATA/CHK is ignored.
//  - ERR: err=1, cpu_hold=1, s_ready=0, no further writes.
//  - mem_we is never asserted outside DATA (no write for a partial word). Address
//    arithmetic is ADDR_W bits; the MAX_WORDS check ensures it never wraps.
// CONFIGURATION
//  PROG_LOADER_CHKSUM_EN defined: one extra byte after the payload = XOR of all payload
//    bytes (length excluded). CHK state accepts it. Match -> DONE. Mismatch -> ERR; cpu_hold
//    stays 1 even though all words were written.
//  Undefined: no CHK state; DONE directly after the last word; no extra byte is consumed.
// STRUCTURE
//  Shared package lab5_pkg: loader state encoding (IDLE,LEN0,LEN1,DATA,CHK,DONE,ERR),
//    LEN_BYTES=2, BYTES_PER_WORD=4.
//  Sub-module byte_packer: 2-bit byte counter + 32-bit shift register; emits word_valid
//    with the word on the 4th byte. prog_loader holds the FSM, address counter and checksum.
// TESTING
//  1 start; 02 00 13 05 10 00 93 05 20 00 -> we @0x00=0x00100513, @0x04=0x00200593;
//    done=1, cpu_hold=0 (+B0 chk byte with macro).
//  2 start; 00 00 -> err=1, cpu_hold=1, no mem_we, s_ready=0.
//  3 start; 41 00 (N=65) -> err=1, no mem_we.
//  4 test1 with s_valid low 1-3 random cycles between bytes -> identical writes/addresses.
//  5 rst_n=0 after 5 bytes of test1 -> all outputs at reset values; then rerun test1 -> passes.
//  6 macro on: test1 + chk 0xB0 -> done=1. Same with 0xB1 -> err=1, cpu_hold=1.
//    Then start + test1 + B0 -> done=1.

Source files
------------

// File: rtl/lab5_pkg.sv
// Shared definitions for the instruction-memory program loader:
// loader state encoding and frame geometry constants.
package lab5_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN0 = 3'd1,
        ST_LEN1 = 3'd2,
        ST_DATA = 3'd3,
        ST_CHK  = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } ld_state_t;

    // Length field is a 16-bit little-endian word count
    localparam int LEN_BYTES      = 2;
    // Payload bytes per instruction word, LSB first
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// byte_packer: collects stream bytes LSB-first into 32-bit words.
// A 2-bit counter tracks the byte position; word_valid is raised together
// with the assembled word in the same cycle the 4th byte is offered.
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt;
    // Only the three earlier bytes need storing; the 4th arrives on byte_in
    logic [23:0] shreg;

    assign word_valid = byte_vld && (cnt == 2'd3);
    assign word       = {byte_in, shreg};

    // Byte position within the current word; cleared when a new load begins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= 2'd0;
        end else if (clr) begin
            cnt <= 2'd0;
        end else if (byte_vld) begin
            cnt <= cnt + 2'd1;
        end
    end

    // Shift bytes in from the top so the first byte ends up in bits [7:0]
    always_ff @(posedge clk) begin
        if (byte_vld) begin
            shreg <= {byte_in, shreg[23:8]};
        end
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed program byte stream, packs it into
// 32-bit little-endian words and writes them to instruction RAM at byte
// addresses 0,4,8,...  The core is held (cpu_hold) until the image is complete.
// Optional feature: define PROG_LOADER_CHKSUM_EN to require a trailing XOR
// checksum byte over the payload before the core is released.
module prog_loader
    import lab5_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    ld_state_t         state;
    logic [7:0]        len_lo;
    logic [15:0]       len_q;
    logic [15:0]       idx_q;
    logic [ADDR_W-1:0] addr_q;
    // Set while the final word's write strobe is on the bus; stalls the stream
    logic              last_wr;
    logic              byte_acc;
    logic              load_go;
    logic              word_valid;
    logic [31:0]       word;
    logic [15:0]       len_in;
`ifdef PROG_LOADER_CHKSUM_EN
    logic [7:0]        chk_q;
`endif

    // s_ready is decoded from registered state only, so it has no input path
    assign s_ready  = (state == ST_LEN0) || (state == ST_LEN1) ||
                      ((state == ST_DATA) && !last_wr) || (state == ST_CHK);
    assign byte_acc = s_valid && s_ready;
    assign load_go  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    assign len_in   = {s_data, len_lo};

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (load_go),
        .byte_vld   (byte_acc && (state == ST_DATA)),
        .byte_in    (s_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // Loader FSM: frame parsing, RAM write strobe, address counter and status
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cpu_hold  <= 1'b1;
            mem_we    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            len_lo    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            addr_q    <= '0;
            last_wr   <= 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
            chk_q     <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (load_go) begin
                        state    <= ST_LEN0;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        cpu_hold <= 1'b1;
                        idx_q    <= '0;
                        addr_q   <= '0;
                        last_wr  <= 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
                        chk_q    <= '0;
`endif
                    end
                end
                ST_LEN0: begin
                    if (byte_acc) begin
                        len_lo <= s_data;
                        state  <= ST_LEN1;
                    end
                end
                ST_LEN1: begin
                    if (byte_acc) begin
                        len_q <= len_in;
                        if ((len_in == 16'd0) || (len_in > 16'(MAX_WORDS))) begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
`ifdef PROG_LOADER_CHKSUM_EN
                    if (byte_acc) begin
                        chk_q <= chk_q ^ s_data;
                    end
`endif
                    if (word_valid) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_q;
                        mem_wdata <= word;
                        addr_q    <= addr_q + ADDR_W'(BYTES_PER_WORD);
                        idx_q     <= idx_q + 16'd1;
                        if (idx_q == len_q - 16'd1) begin
                            last_wr <= 1'b1;
                        end
                    end
                    // Leave DATA only after the final write strobe has been issued
                    if (last_wr) begin
                        last_wr <= 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
                        state   <= ST_CHK;
`else
                        state    <= ST_DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
`endif
                    end
                end
`ifdef PROG_LOADER_CHKSUM_EN
                ST_CHK: begin
                    if (byte_acc) begin
                        if (s_data == chk_q) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: drives framed byte streams with random gaps and
// compares every RAM write and the final status against a frame-level model.
module tb_prog_loader;

    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        s_data = 8'h00;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic              cpu_hold;
    logic              done;
    logic              err;

    prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  fr[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int          exp_done;
    int          exp_err;
    logic        prev_we = 1'b0;
    logic        prev_done = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Frame-level model: expected writes and final status for the first nsent bytes of fr
    task automatic model(input int nsent);
        int n;
        int words;
        logic [7:0] x;
        exp_done = 0;
        exp_err  = 0;
        if (nsent < 2) return;
        n = int'(fr[0]) + 256 * int'(fr[1]);
        if (n == 0 || n > MAX_WORDS) begin
            exp_err = 1;
            return;
        end
        words = (nsent - 2) / 4;
        if (words > n) words = n;
        for (int i = 0; i < words; i++) begin
            exp_addr_q.push_back(32'((4 * i) % (1 << ADDR_W)));
            exp_data_q.push_back({fr[2+4*i+3], fr[2+4*i+2], fr[2+4*i+1], fr[2+4*i]});
        end
        if (words == n) begin
`ifdef PROG_LOADER_CHKSUM_EN
            if (nsent >= 2 + 4 * n + 1) begin
                x = 8'h00;
                for (int j = 0; j < 4 * n; j++) x = x ^ fr[2+j];
                if (fr[2+4*n] == x) exp_done = 1;
                else exp_err = 1;
            end
`else
            exp_done = 1;
`endif
        end
    endtask

    // Build a random frame of n words; bad_mod != 0 corrupts the checksum byte
    task automatic build_frame(input int n, input logic [7:0] bad_mod);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        fr.delete();
        fr.push_back(8'(n));
        fr.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            x = x ^ b;
            fr.push_back(b);
        end
`ifdef PROG_LOADER_CHKSUM_EN
        fr.push_back(x ^ bad_mod);
`else
        if (bad_mod != 8'h00) x = 8'h00;
`endif
    endtask

    task automatic load_test1(input logic [7:0] chk);
        fr = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
`ifdef PROG_LOADER_CHKSUM_EN
        fr.push_back(chk);
`else
        if (chk == 8'h00) fr.push_back(8'h00);
`endif
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Offer fr[from..to-1] with mingap..maxgap idle cycles before each byte
    task automatic send_bytes(input int from, input int to, input int mingap, input int maxgap);
        int k;
        for (int i = from; i < to; i++) begin
            repeat ($urandom_range(mingap, maxgap)) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
                @(posedge clk);
                #1;
            end
            s_valid = 1'b1;
            s_data  = fr[i];
            @(negedge clk);
            k = 0;
            while (!s_ready && k < 50) begin
                @(negedge clk);
                k++;
            end
            if (!s_ready) begin
                total++;
                bad++;
                $display("FAIL byte_accept_timeout: byte %0d s_ready=%0b required 1", i, s_ready);
                s_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1 s_valid = 1'b0;
        end
    endtask

    task automatic finish_check(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (!(done || err) && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_cpu_hold"}, 32'(cpu_hold), exp_done ? 32'd0 : 32'd1);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_writes_left"}, 32'(exp_addr_q.size()), 32'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    task automatic run_frame(input string tag, input int mingap, input int maxgap);
        pulse_start();
        model(fr.size());
        send_bytes(0, fr.size(), mingap, maxgap);
        finish_check(tag);
    endtask

    // Compare process: every write strobe must match the next expected write
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                if (exp_addr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_we: addr=%0h data=%0h required no write", mem_addr, mem_wdata);
                end else begin
                    check("we_addr", 32'(mem_addr), exp_addr_q.pop_front());
                    check("we_data", mem_wdata, exp_data_q.pop_front());
                end
            end
`ifndef PROG_LOADER_CHKSUM_EN
            if (done && !prev_done) check("done_after_last_we", 32'(prev_we), 32'd1);
`endif
        end
        prev_we   = mem_we;
        prev_done = done;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        #1 rst_n = 1'b1;

        // Test 1: reference program; pin the model against hand-computed words
        load_test1(8'hB0);
        pulse_start();
        model(fr.size());
        check("model_w0_data", exp_data_q[0], 32'h00100513);
        check("model_w1_data", exp_data_q[1], 32'h00200593);
        check("model_w1_addr", exp_addr_q[1], 32'h00000004);
        check("model_t1_done", 32'(exp_done), 32'd1);
        send_bytes(0, fr.size(), 0, 0);
        finish_check("t1");

        // Test 2: zero length
        fr = '{8'h00, 8'h00};
        run_frame("t2_len0", 0, 0);

        // Test 3: N = MAX_WORDS + 1
        fr = '{8'h41, 8'h00};
        check("model_t3_err", 32'(1), 32'(1) & 32'(fr[0] == 8'h41));
        run_frame("t3_len65", 0, 0);

        // Test 4: reference program with 1..3 idle cycles between bytes
        load_test1(8'hB0);
        run_frame("t4_gaps", 1, 3);

        // Test 5: reset after 5 bytes, then rerun
        load_test1(8'hB0);
        pulse_start();
        model(5);
        send_bytes(0, 5, 0, 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t5_cpu_hold", 32'(cpu_hold), 32'd1);
        check("t5_s_ready", 32'(s_ready), 32'd0);
        check("t5_mem_we", 32'(mem_we), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_err", 32'(err), 32'd0);
        check("t5_mem_addr", 32'(mem_addr), 32'd0);
        check("t5_mem_wdata", mem_wdata, 32'd0);
        check("t5_no_writes", 32'(exp_addr_q.size()), 32'd0);
        #1 rst_n = 1'b1;
        load_test1(8'hB0);
        run_frame("t5_rerun", 0, 2);

`ifdef PROG_LOADER_CHKSUM_EN
        // Test 6: wrong checksum holds the core, correct one releases it
        load_test1(8'hB1);
        run_frame("t6_badchk", 0, 1);
        load_test1(8'hB0);
        run_frame("t6_goodchk", 0, 1);
`endif

        // Random frames, random gaps
        for (int t = 0; t < 8; t++) begin
            build_frame($urandom_range(1, 8), (t == 3) ? 8'h5A : 8'h00);
            run_frame("rnd", 0, 2);
        end

        // Largest frame: last word lands at 0xFC
        build_frame(MAX_WORDS, 8'h00);
        run_frame("max", 0, 0);

        // start during DATA is ignored
        build_frame(3, 8'h00);
        pulse_start();
        model(fr.size());
        send_bytes(0, 6, 0, 0);
        pulse_start();
        send_bytes(6, fr.size(), 0, 1);
        finish_check("start_mid");

        // After DONE, offered bytes are not consumed
        s_valid = 1'b1;
        s_data  = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("done_s_ready", 32'(s_ready), 32'd0);
        end
        #1 s_valid = 1'b0;

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
